skeleton_trace_fifo: RTL and testbench
======================================

Name: skeleton_trace_fifo

Overview:
Debug capture stage downstream of the processor skeleton. It snoops the regfile write port and the dmem write port, timestamps each committed write, and buffers the events in a FIFO. A bench or host drains the FIFO through a valid/ready interface. It gives post-silicon and simulation visibility of architectural state changes without touching the processor datapath.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries)
STAMP_W, 16, width of free-running cycle timestamp

Ports:
clock  in  1  system clock; all state on the rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  capture enable; 0 = ignore snooped writes
clear  in  1  synchronous flush of FIFO, skid register, drop counter and overflow flag
ctrl_writeEnable  in  1  regfile write enable (snooped)
ctrl_writeReg  in  5  regfile destination (snooped)
data_writeReg  in  32  regfile write data (snooped)
wren  in  1  dmem write enable (snooped)
address_dmem  in  12  dmem address (snooped)
data  in  32  dmem write data (snooped)
trace_valid  out  1  head entry available
trace_ready  in  1  consumer accepts head entry
trace_kind  out  1  0 = regfile write, 1 = dmem write
trace_addr  out  12  register number (zero-extended) or dmem address
trace_data  out  32  written value
trace_stamp  out  STAMP_W  cycle stamp at capture
count  out  DEPTH_LOG2+1  FIFO occupancy (skid excluded)
drop_count  out  16  events lost, saturating
overflow  out  1  sticky: at least one event dropped

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, skid empty, stamp counter 0, drop_count 0, overflow 0. All outputs read 0, including trace_kind, trace_addr, trace_data and trace_stamp.
- Stamp counter increments every cycle out of reset and wraps modulo 2^STAMP_W. It is unaffected by enable and clear.
- Reg event: enable & ctrl_writeEnable & (ctrl_writeReg != 0). Entry = {0, {7'b0, ctrl_writeReg}, data_writeReg, stamp}.
- Mem event: enable & wren. Entry = {1, address_dmem, data, stamp}.
- Writes to r0 are never captured.
- FIFO is show-ahead: trace_valid = (count != 0); head fields are stable while trace_valid & ~trace_ready.
- Pop occurs when trace_valid & trace_ready.
- Latency: an event captured in cycle n into an empty FIFO is visible (trace_valid=1) in cycle n+1.
- The FIFO accepts at most one push per cycle.
- Push space exists when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
- Candidates each cycle, in priority order: skid entry, reg event, mem event.
  - If space exists, the first candidate is pushed.
  - The next candidate is loaded into the skid if the skid is empty or is being pushed this cycle.
  - Any remaining candidate is dropped.
- If no space exists, the skid holds its contents and all new events are dropped.
- A skid entry keeps its original stamp.
- Each dropped event increments drop_count by 1; drop_count saturates at 16'hFFFF.
- Any drop sets overflow. Overflow stays set until clear or reset.
- Both reg and mem events dropped in one cycle count as +2 (saturating).
- clear=1: next cycle count=0, skid empty, drop_count=0, overflow=0, trace_valid=0.
  - Events arriving in a clear cycle are discarded and not counted.
  - A pop requested in a clear cycle is irrelevant.
- Pointers are DEPTH_LOG2 bits and wrap naturally; occupancy is tracked separately. No full/empty ambiguity.
- Reset asserted mid-operation discards all contents immediately; no partial entry is ever presented.

Test Plan:
- Single reg write: ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=32'hDEADBEEF at stamp 10, trace_ready=0 -> cycle later trace_valid=1, kind=0, addr=12'h005, data=32'hDEADBEEF, stamp=10, count=1; raise ready -> count=0.
- r0 filter and enable gating: write to reg 0, then reg 3 with enable=0 -> trace_valid stays 0, drop_count=0.
- Simultaneous events: reg 7=32'h1 and dmem addr 12'h040=32'h2 in the same cycle, ready=1 -> reg entry emitted first, mem entry next cycle with the same stamp, no drops.
- Full FIFO: ready=0, 17 single reg writes -> count=16, overflow=1, drop_count=1. On the next event with ready=1 and a pop in the same cycle -> push accepted, count stays 16.
- Saturation: ready=0, FIFO full, 70000 mem writes -> drop_count=16'hFFFF. Assert clear -> drop_count=0, overflow=0, count=0, trace_valid=0.
- Async reset: assert reset=0 mid-cycle with 5 entries queued -> outputs 0 immediately, without waiting for a clock edge. After release, stamp restarts at 0.

Source files
------------

// File: rtl/skeleton_trace_fifo.sv
// Debug trace capture: snoops regfile and dmem writes, stamps each one, and
// queues the events in a show-ahead FIFO drained over a valid/ready interface.
module skeleton_trace_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int STAMP_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  ctrl_writeEnable,
    input  logic [4:0]            ctrl_writeReg,
    input  logic [31:0]           data_writeReg,
    input  logic                  wren,
    input  logic [11:0]           address_dmem,
    input  logic [31:0]           data,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic                  trace_kind,
    output logic [11:0]           trace_addr,
    output logic [31:0]           trace_data,
    output logic [STAMP_W-1:0]    trace_stamp,
    output logic [DEPTH_LOG2:0]   count,
    output logic [15:0]           drop_count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef struct packed {
        logic               kind;
        logic [11:0]        addr;
        logic [31:0]        data;
        logic [STAMP_W-1:0] stamp;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [STAMP_W-1:0]    stamp;
    entry_t                skid;
    logic                  skid_valid;

    entry_t     reg_entry;
    entry_t     mem_entry;
    entry_t     push_entry;
    entry_t     skid_entry;
    entry_t     head;
    logic       reg_evt;
    logic       mem_evt;
    logic       pop;
    logic       space;
    logic       push;
    logic       skid_load;
    logic       skid_valid_next;
    logic [1:0] drops;
    logic [16:0] drop_sum;

    assign reg_evt   = enable & ctrl_writeEnable & (ctrl_writeReg != 5'd0);
    assign mem_evt   = enable & wren;
    assign reg_entry = '{kind: 1'b0, addr: {7'b0, ctrl_writeReg}, data: data_writeReg, stamp: stamp};
    assign mem_entry = '{kind: 1'b1, addr: address_dmem, data: data, stamp: stamp};

    assign trace_valid = (count != '0);
    assign pop         = trace_valid & trace_ready;
    assign space       = (count != FULL_COUNT) | pop;

    // Candidate order is skid, reg, mem: the first goes to the FIFO, the second
    // parks in the skid, anything beyond that is lost.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        push            = 1'b0;
        push_entry      = reg_entry;
        skid_load       = 1'b0;
        skid_entry      = mem_entry;
        skid_valid_next = skid_valid;
        drops           = 2'd0;
        if (space) begin
            skid_valid_next = 1'b0;
            if (skid_valid) begin
                push       = 1'b1;
                push_entry = skid;
                if (reg_evt) begin
                    skid_load  = 1'b1;
                    skid_entry = reg_entry;
                    drops      = {1'b0, mem_evt};
                end else if (mem_evt) begin
                    skid_load  = 1'b1;
                    skid_entry = mem_entry;
                end
            end else if (reg_evt) begin
                push       = 1'b1;
                push_entry = reg_entry;
                skid_load  = mem_evt;
            end else if (mem_evt) begin
                push       = 1'b1;
                push_entry = mem_entry;
            end
            if (skid_load) skid_valid_next = 1'b1;
        end else begin
            drops = {1'b0, reg_evt} + {1'b0, mem_evt};
        end
    end

    assign drop_sum = {1'b0, drop_count} + {15'b0, drops};

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            stamp      <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            skid_valid <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            stamp <= stamp + 1'b1;
            if (clear) begin
                count      <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                skid_valid <= 1'b0;
                drop_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count      <= count + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
                skid_valid <= skid_valid_next;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                if (drops != 2'd0) overflow <= 1'b1;
            end
        end
    end

    // NOTE: storage and skid payload carry no reset; the occupancy count and
    // skid_valid decide what is meaningful, and the outputs are masked below.
    always_ff @(posedge clock) begin
        if (push && !clear)      mem[wr_ptr] <= push_entry;
        if (skid_load && !clear) skid        <= skid_entry;
    end

    assign head        = trace_valid ? mem[rd_ptr] : '0;
    assign trace_kind  = head.kind;
    assign trace_addr  = head.addr;
    assign trace_data  = head.data;
    assign trace_stamp = head.stamp;

endmodule

// File: tb/tb_skeleton_trace_fifo.sv
// Self-checking bench for skeleton_trace_fifo: queue-based reference model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_skeleton_trace_fifo;

    localparam int DEPTH = 16;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        clear;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        wren;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        trace_valid;
    logic        trace_ready;
    logic        trace_kind;
    logic [11:0] trace_addr;
    logic [31:0] trace_data;
    logic [15:0] trace_stamp;
    logic [4:0]  count;
    logic [15:0] drop_count;
    logic        overflow;

    skeleton_trace_fifo #(.DEPTH_LOG2(4), .STAMP_W(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .wren(wren), .address_dmem(address_dmem),
        .data(data), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_kind(trace_kind), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_stamp(trace_stamp), .count(count), .drop_count(drop_count),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, candidates are a list.
    typedef struct {
        logic        kind;
        logic [11:0] addr;
        logic [31:0] data;
        logic [15:0] stamp;
    } ev_t;

    ev_t  q[$];
    ev_t  cands[$];
    ev_t  m_skid;
    ev_t  ev;
    bit   m_skid_v;
    int   m_drop;
    bit   m_ovf;
    int   m_stamp;
    int   new_events;
    int   dropped;
    bit   do_pop;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_skid_v = 0;
            m_drop   = 0;
            m_ovf    = 0;
            m_stamp  = 0;
        end else begin
            do_pop = (q.size() != 0) && trace_ready;
            if (clear) begin
                q.delete();
                m_skid_v = 0;
                m_drop   = 0;
                m_ovf    = 0;
            end else begin
                cands.delete();
                new_events = 0;
                if (m_skid_v) cands.push_back(m_skid);
                if (enable && ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
                    ev = '{1'b0, {7'b0, ctrl_writeReg}, data_writeReg, 16'(m_stamp)};
                    cands.push_back(ev);
                    new_events++;
                end
                if (enable && wren) begin
                    ev = '{1'b1, address_dmem, data, 16'(m_stamp)};
                    cands.push_back(ev);
                    new_events++;
                end
                if (do_pop) void'(q.pop_front());
                dropped = 0;
                if (q.size() < DEPTH) begin
                    m_skid_v = 0;
                    if (cands.size() > 0) q.push_back(cands[0]);
                    if (cands.size() > 1) begin
                        m_skid   = cands[1];
                        m_skid_v = 1;
                    end
                    if (cands.size() > 2) dropped = cands.size() - 2;
                end else begin
                    dropped = new_events;
                end
                m_drop = m_drop + dropped;
                if (m_drop > 65535) m_drop = 65535;
                if (dropped != 0) m_ovf = 1;
            end
            m_stamp = (m_stamp + 1) % 65536;
        end
    end

    always @(negedge clock) begin
        check("valid", trace_valid, q.size() != 0);
        check("count", count, q.size());
        check("drop_count", drop_count, m_drop);
        check("overflow", overflow, m_ovf);
        if (q.size() != 0) begin
            check("head_kind", trace_kind, q[0].kind);
            check("head_addr", trace_addr, q[0].addr);
            check("head_data", trace_data, q[0].data);
            check("head_stamp", trace_stamp, q[0].stamp);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        enable           = 1'b1;
        clear            = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        wren             = 1'b0;
        address_dmem     = 12'd0;
        data             = 32'd0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, trace_valid, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_kind"}, trace_kind, 0);
        check({tag, "_addr"}, trace_addr, 0);
        check({tag, "_data"}, trace_data, 0);
        check({tag, "_stamp"}, trace_stamp, 0);
        check({tag, "_drop"}, drop_count, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        reset       = 1'b0;
        trace_ready = 1'b0;
        idle_inputs();
        repeat (3) cyc();
        check_all_zero("reset");

        // Single reg write captured at stamp 10.
        reset = 1'b1;
        repeat (10) cyc();
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'hDEADBEEF;
        cyc();
        idle_inputs();
        check("single_valid", trace_valid, 1);
        check("single_kind", trace_kind, 0);
        check("single_addr", trace_addr, 12'h005);
        check("single_data", trace_data, 32'hDEADBEEF);
        check("single_stamp", trace_stamp, 16'd10);
        check("single_count", count, 1);
        trace_ready = 1'b1;
        cyc();
        trace_ready = 1'b0;
        check("single_pop_count", count, 0);

        // r0 filter and enable gating.
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'h1234;
        cyc();
        enable        = 1'b0;
        ctrl_writeReg = 5'd3;
        cyc();
        idle_inputs();
        cyc();
        check("filter_valid", trace_valid, 0);
        check("filter_drop", drop_count, 0);

        // Simultaneous reg + mem events with ready held high.
        trace_ready      = 1'b1;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h1;
        wren             = 1'b1;
        address_dmem     = 12'h040;
        data             = 32'h2;
        cyc();
        idle_inputs();
        check("simul_first_kind", trace_kind, 0);
        check("simul_first_addr", trace_addr, 12'h007);
        check("simul_first_data", trace_data, 32'h1);
        begin
            logic [15:0] s0;
            s0 = trace_stamp;
            cyc();
            check("simul_second_valid", trace_valid, 1);
            check("simul_second_kind", trace_kind, 1);
            check("simul_second_addr", trace_addr, 12'h040);
            check("simul_second_data", trace_data, 32'h2);
            check("simul_second_stamp", trace_stamp, s0);
        end
        cyc();
        check("simul_empty", count, 0);
        check("simul_drop", drop_count, 0);
        trace_ready = 1'b0;

        // Fill to DEPTH, then one more to overflow.
        do_clear();
        for (int i = 0; i < 17; i++) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = 5'(i + 1);
            data_writeReg    = 32'(100 + i);
            cyc();
        end
        idle_inputs();
        check("full_count", count, 16);
        check("full_ovf", overflow, 1);
        check("full_drop", drop_count, 1);
        check("full_head", trace_data, 32'd100);
        trace_ready      = 1'b1;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd20;
        data_writeReg    = 32'd200;
        cyc();
        idle_inputs();
        trace_ready = 1'b0;
        check("full_pushpop_count", count, 16);
        check("full_pushpop_drop", drop_count, 1);
        check("full_pushpop_head", trace_data, 32'd101);

        // Saturate the drop counter with mem writes, then clear.
        wren = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            address_dmem = 12'(i);
            cyc();
        end
        idle_inputs();
        check("sat_drop", drop_count, 16'hFFFF);
        check("sat_ovf", overflow, 1);
        do_clear();
        check("clear_drop", drop_count, 0);
        check("clear_ovf", overflow, 0);
        check("clear_count", count, 0);
        check("clear_valid", trace_valid, 0);

        // Randomized traffic with phased consumer rate.
        for (int i = 0; i < 3000; i++) begin
            enable           = ($urandom_range(0, 15) != 0);
            ctrl_writeEnable = ($urandom_range(0, 2) != 0);
            ctrl_writeReg    = 5'($urandom_range(0, 31));
            data_writeReg    = $urandom;
            wren             = ($urandom_range(0, 2) == 0);
            address_dmem     = 12'($urandom);
            data             = $urandom;
            clear            = ($urandom_range(0, 127) == 0);
            case ((i / 250) % 3)
                0:       trace_ready = ($urandom_range(0, 3) == 0);
                1:       trace_ready = ($urandom_range(0, 3) != 0);
                default: trace_ready = $urandom_range(0, 1);
            endcase
            cyc();
        end
        idle_inputs();
        trace_ready = 1'b0;

        // Asynchronous reset with five entries queued.
        do_clear();
        for (int i = 0; i < 5; i++) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = 5'(i + 1);
            data_writeReg    = 32'(i);
            cyc();
        end
        idle_inputs();
        check("pre_reset_count", count, 5);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clock);
        #1;
        reset            = 1'b1;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h55;
        cyc();
        idle_inputs();
        check("restart_valid", trace_valid, 1);
        check("restart_stamp", trace_stamp, 0);
        check("restart_data", trace_data, 32'h55);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
